// File: rtl/gpu_mem_pkg.sv
// Shared types and limits for the GPU memory responder and its per-channel engines.
package gpu_mem_pkg;

  localparam int unsigned MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } mem_chan_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, waits LATENCY cycles, strobes ready once,
// then holds off until the initiator drops valid.
module mem_responder_channel
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned WRITABLE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 read_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wr_en,
  output logic [DATA_BITS-1:0] mem_wr_data,
  output logic                 busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_chan_state_t        state, state_nxt;
  mem_op_t                op, op_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]   addr, addr_nxt;
  logic [DATA_BITS-1:0]   data, data_nxt;
  logic                   wr_take;

  assign wr_take = (WRITABLE != 0) && write_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op    <= OP_READ;
      cnt   <= '0;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    data_nxt  = data;
    unique case (state)
      IDLE: begin
        if (wr_take) begin
          op_nxt    = OP_WRITE;
          addr_nxt  = write_address;
          data_nxt  = write_data;
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end else if (read_valid) begin
          op_nxt    = OP_READ;
          addr_nxt  = read_address;
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RESP: state_nxt = DRAIN;
      DRAIN: begin
        // Only the valid of the op just serviced releases the channel.
        if (op == OP_WRITE ? !write_valid : !read_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign read_ready  = (state == RESP) && (op == OP_READ);
  assign mem_wr_en   = (state == RESP) && (op == OP_WRITE);
  assign mem_addr    = addr;
  assign mem_wr_data = data;
  assign busy        = (state != IDLE);

endmodule

// File: rtl/mem_responder.sv
// Multi-channel synthesizable responder for the GPU memory valid/ready protocol,
// with a backdoor load port for preloading program/data images.
module mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned WRITABLE  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]   read_address,
  output logic [CHANNELS-1:0]             read_ready,
  output logic [CHANNELS*DATA_BITS-1:0]   read_data,
  input  logic [CHANNELS-1:0]             write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]   write_address,
  input  logic [CHANNELS*DATA_BITS-1:0]   write_data,
  output logic [CHANNELS-1:0]             write_ready,
  input  logic                            load_en,
  input  logic [ADDR_BITS-1:0]            load_addr,
  input  logic [DATA_BITS-1:0]            load_data,
  output logic                            busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] ch_addr    [CHANNELS];
  logic [DATA_BITS-1:0] ch_wr_data [CHANNELS];
  logic [DATA_BITS-1:0] rd_hold    [CHANNELS];
  logic [CHANNELS-1:0]  ch_wr_en;
  logic [CHANNELS-1:0]  ch_busy;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mem_responder_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY),
      .WRITABLE  (WRITABLE)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .read_valid    (read_valid[g]),
      .read_address  (read_address[g*ADDR_BITS +: ADDR_BITS]),
      .write_valid   (write_valid[g]),
      .write_address (write_address[g*ADDR_BITS +: ADDR_BITS]),
      .write_data    (write_data[g*DATA_BITS +: DATA_BITS]),
      .read_ready    (read_ready[g]),
      .mem_addr      (ch_addr[g]),
      .mem_wr_en     (ch_wr_en[g]),
      .mem_wr_data   (ch_wr_data[g]),
      .busy          (ch_busy[g])
    );
  end

  assign write_ready = ch_wr_en;
  assign busy        = |ch_busy;

  // Later assignments override earlier ones: load first, then channels in
  // ascending order so the highest channel index wins a collision.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch_wr_en[c]) mem[ch_addr[c]] <= ch_wr_data[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) rd_hold[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (read_ready[c]) rd_hold[c] <= mem[ch_addr[c]];
      end
    end
  end

  // Live array read during RESP gives read-before-write against same-cycle commits.
  always_comb begin
    read_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      read_data[c*DATA_BITS +: DATA_BITS] = read_ready[c] ? mem[ch_addr[c]] : rd_hold[c];
    end
  end

endmodule
